// File: rtl/flash_reader.sv
// Word-read controller for the parallel NOR flash: writes read-array (0x00FF) after reset, then serves single-word reads.
// Optional macro FLASH_REISSUE_CMD_EN: re-issue the read-array command in front of every read.
module flash_reader #(
  parameter int READ_WAIT_CYCLES    = 8,
  parameter int WE_PULSE_CYCLES     = 4,
  parameter int CMD_RECOVERY_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flash_need_to_work,
  input  logic [22:1] flash_addr,
  output logic        flash_work_done,
  output logic [15:0] flash_data,
  output logic [15:0] flash_done_addr,
  output logic [22:1] flash_a,
  inout  wire  [15:0] flash_d,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_byte_n,
  output logic        flash_vpen,
  output logic        flash_rp_n
);

  typedef enum logic [2:0] {
    CMD_WE, CMD_HOLD, CMD_REC, IDLE, READ, DONE, RELEASE
  } state_t;

  localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;
  localparam logic [7:0]  READ_LAST      = 8'(READ_WAIT_CYCLES - 1);
  localparam logic [7:0]  WE_LAST        = 8'(WE_PULSE_CYCLES - 1);
  localparam logic [7:0]  REC_LAST       = 8'(CMD_RECOVERY_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        done_q;
  logic [15:0] data_q;
  logic [15:0] done_addr_q;
  logic [22:1] a_q;
  logic        ce_n_q, oe_n_q, we_n_q, d_oe_q, rp_n_q;
`ifdef FLASH_REISSUE_CMD_EN
  logic        rd_pend_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CMD_WE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      data_q      <= '0;
      done_addr_q <= '0;
      a_q         <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      d_oe_q      <= 1'b0;
      rp_n_q      <= 1'b0;
`ifdef FLASH_REISSUE_CMD_EN
      rd_pend_q   <= 1'b0;
`endif
    end else begin
      rp_n_q <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        CMD_WE: begin
          // we_n still high means we just left reset: open the write pulse now
          if (we_n_q) begin
            ce_n_q <= 1'b0;
            we_n_q <= 1'b0;
            d_oe_q <= 1'b1;
            cnt_q  <= '0;
          end else if (cnt_q == WE_LAST) begin
            we_n_q  <= 1'b1;
            state_q <= CMD_HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        CMD_HOLD: begin
          ce_n_q  <= 1'b1;
          d_oe_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= CMD_REC;
        end
        CMD_REC: begin
          if (cnt_q == REC_LAST) begin
`ifdef FLASH_REISSUE_CMD_EN
            if (rd_pend_q) begin
              rd_pend_q <= 1'b0;
              ce_n_q    <= 1'b0;
              oe_n_q    <= 1'b0;
              cnt_q     <= '0;
              state_q   <= READ;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        IDLE: begin
          if (flash_need_to_work) begin
            a_q    <= flash_addr;
            cnt_q  <= '0;
            ce_n_q <= 1'b0;
`ifdef FLASH_REISSUE_CMD_EN
            we_n_q    <= 1'b0;
            d_oe_q    <= 1'b1;
            rd_pend_q <= 1'b1;
            state_q   <= CMD_WE;
`else
            oe_n_q  <= 1'b0;
            state_q <= READ;
`endif
          end
        end
        READ: begin
          if (cnt_q == READ_LAST) begin
            data_q      <= flash_d;
            done_addr_q <= a_q[16:1];
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: state_q <= RELEASE;
        RELEASE: begin
          // a held request must be dropped before another read is accepted
          if (!flash_need_to_work) state_q <= IDLE;
        end
        default: begin
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          d_oe_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign flash_d         = d_oe_q ? READ_ARRAY_CMD : 16'hzzzz;
  assign flash_work_done = done_q;
  assign flash_data      = data_q;
  assign flash_done_addr = done_addr_q;
  assign flash_a         = a_q;
  assign flash_ce_n      = ce_n_q;
  assign flash_oe_n      = oe_n_q;
  assign flash_we_n      = we_n_q;
  assign flash_rp_n      = rp_n_q;
  assign flash_byte_n    = 1'b1;
  assign flash_vpen      = 1'b0;

endmodule

// File: tb/tb_flash_reader.sv
// Randomized bench for flash_reader with a behavioural NOR flash model and protocol monitor.
`timescale 1ns/1ps
module tb_flash_reader;
  localparam int RW  = 8;
  localparam int WEP = 4;
  localparam int REC = 2;
`ifdef FLASH_REISSUE_CMD_EN
  localparam int REISSUE = 1;
`else
  localparam int REISSUE = 0;
`endif
  localparam int LAT   = RW + REISSUE * (WEP + 1 + REC);
  localparam int NRAND = 16;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [22:1] addr;
  logic        done;
  logic [15:0] data, done_addr;
  logic [22:1] fa;
  wire  [15:0] fd;
  logic        ce_n, oe_n, we_n, byte_n, vpen, rp_n;

  logic [22:1] ovr_addr;
  logic [15:0] ovr_val, mem_rd;
  int n_vec = 0, n_err = 0, we_pulses = 0, n_done = 0;

  flash_reader #(
    .READ_WAIT_CYCLES(RW), .WE_PULSE_CYCLES(WEP), .CMD_RECOVERY_CYCLES(REC)
  ) dut (
    .clk(clk), .rst(rst), .flash_need_to_work(req), .flash_addr(addr),
    .flash_work_done(done), .flash_data(data), .flash_done_addr(done_addr),
    .flash_a(fa), .flash_d(fd), .flash_ce_n(ce_n), .flash_oe_n(oe_n),
    .flash_we_n(we_n), .flash_byte_n(byte_n), .flash_vpen(vpen), .flash_rp_n(rp_n)
  );

  initial forever #5 clk = ~clk;

  // Flash contents: one programmable word, everything else a fixed hash of the address
  function automatic logic [15:0] word_at(input logic [22:1] a, input logic [22:1] oa,
                                          input logic [15:0] ov);
    if (a == oa) return ov;
    return a[16:1] ^ {a[22:17], a[22:13]} ^ 16'hA5C3;
  endfunction

  always_comb mem_rd = word_at(fa, ovr_addr, ovr_val);
  assign fd = (!ce_n && !oe_n) ? mem_rd : 16'hzzzz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Protocol monitor: command-write pulse shape and read strobe window
  initial begin
    int  we_run, oe_run;
    logic prev_we, prev_oe;
    we_run = 0; oe_run = 0; prev_we = 1'b1; prev_oe = 1'b1;
    forever begin
      @(negedge clk);
      if (!rp_n) begin
        we_run = 0; oe_run = 0; prev_we = 1'b1; prev_oe = 1'b1;
      end else begin
        if (!we_n) begin
          we_run++;
          chk("cmd_bus", {ce_n, oe_n, fd}, {1'b0, 1'b1, 16'h00FF});
        end else if (!prev_we) begin
          chk("we_width", we_run, WEP);
          chk("cmd_hold_ce", ce_n, 1'b0);
          we_pulses++;
          we_run = 0;
        end
        if (!oe_n) begin
          oe_run++;
          chk("rd_strobes", {ce_n, we_n}, 2'b01);
        end else if (!prev_oe) begin
          chk("oe_width", oe_run, RW);
          chk("done_with_oe_rise", done, 1'b1);
          oe_run = 0;
        end
        if (done) n_done++;
        prev_we = we_n;
        prev_oe = oe_n;
      end
    end
  end

  task automatic do_read(input logic [22:1] a, input logic [15:0] v, input bit chg);
    int k, wp0;
    bit seen;
    ovr_addr = a; ovr_val = v; addr = a; req = 1'b1;
    wp0 = we_pulses; seen = 1'b0; k = 0;
    while (!seen && k < LAT + 20) begin
      @(negedge clk);
      k++;
      if (chg && k == LAT - 2) addr = a ^ 22'($urandom_range(1, 32'h3FFFFF));
      if (done) seen = 1'b1;
    end
    chk("read_latency", seen ? k : -1, LAT + 1);
    chk("read_data", data, v);
    chk("read_done_addr", done_addr, a[16:1]);
    chk("read_flash_a", fa, a);
    chk("cmd_per_read", we_pulses - wp0, REISSUE);
    @(negedge clk);
    chk("done_single", done, 1'b0);
  endtask

  initial begin
    int k, wp0, nd0, ce_low;
    logic [22:1] ra;
    logic [15:0] rv, prev_v;
    rst = 1'b0; req = 1'b0; addr = '0; ovr_addr = 22'h000001; ovr_val = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 1'b0);
    chk("rst_data", data, 16'h0);
    chk("rst_done_addr", done_addr, 16'h0);
    chk("rst_a", fa, 22'h0);
    chk("rst_strobes", {ce_n, oe_n, we_n, rp_n}, 4'b1110);
    chk("const_pins", {byte_n, vpen}, 2'b10);

    rst = 1'b1;
    repeat (WEP + REC + 4) @(negedge clk);
    chk("boot_cmd_count", we_pulses, 1);
    chk("boot_idle", {ce_n, oe_n, we_n, rp_n, done}, 5'b11110);

    do_read(22'h000001, 16'h1234, 1'b0);

    ce_low = 0;
    repeat (40) begin
      @(negedge clk);
      if (!ce_n) ce_low++;
    end
    chk("held_req_no_read", ce_low, 0);
    req = 1'b0;
    @(negedge clk);
    do_read(22'h000001, 16'h4321, 1'b0);

    req = 1'b0;
    repeat (3) @(negedge clk);
    do_read(22'h012345, 16'hBEEF, 1'b1);

    // Reset during the fourth read cycle; the held request must complete afterwards
    req = 1'b0;
    repeat (3) @(negedge clk);
    ovr_addr = 22'h00ABCD; ovr_val = 16'h5EED; addr = 22'h00ABCD; req = 1'b1;
    wp0 = we_pulses; nd0 = n_done; k = 0;
    while (oe_n && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("abort_read_started", oe_n, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {ce_n, oe_n, we_n, rp_n, done}, 5'b11100);
    chk("abort_no_done", n_done - nd0, 0);
    rst = 1'b1;
    k = 0;
    while (!done && k < LAT + 40) begin
      @(negedge clk);
      k++;
    end
    chk("abort_recover_latency", k, 9 + LAT);
    chk("abort_recover_data", data, 16'h5EED);
    chk("abort_recover_addr", done_addr, 16'hABCD);
    chk("abort_cmd_count", we_pulses - wp0, 1 + 2 * REISSUE);
    @(negedge clk);
    chk("abort_done_single", done, 1'b0);

    prev_v = 16'h5EED;
    for (int i = 0; i < NRAND; i++) begin
      req = 1'b0;
      repeat ($urandom_range(3, 6)) @(negedge clk);
      chk("data_held", data, prev_v);
      ra = 22'($urandom);
      rv = 16'($urandom);
      do_read(ra, rv, 1'($urandom));
      prev_v = rv;
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_count", n_done, 4 + NRAND);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
